// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: read-data ownership tags
// and the fixed grant-to-data read latency.
package vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/vram_tag_pipe.sv
// Ownership tag shift register: carries the owner of each granted read
// alongside the VRAM access so the returning data can be steered.
module vram_tag_pipe
  import vram_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t owner_in,
  output owner_t owner_out
);

  owner_t stage_reg [RD_LATENCY];

  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg[gi] <= OWN_NONE;
        end else if (gi == 0) begin
          stage_reg[gi] <= owner_in;
        end else begin
          stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign owner_out = stage_reg[RD_LATENCY-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed video priority with a CPU starvation limiter.
// Optional statistics counters are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]       cpu_stall_cnt,
  output logic [15:0]       vid_grant_cnt,
  input  logic              stats_clr,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  owner_t     owner_in, owner_ret;

  // CPU wins only when video is absent or the CPU has waited out its limit.
  assign cpu_gnt = cpu_req && (!vid_req || (starve_cnt_reg == STARVE_LIM));
  assign vid_gnt = vid_req && !cpu_gnt;

  always_comb begin
    owner_in = OWN_NONE;
    if (vid_gnt) begin
      owner_in = OWN_VID;
    end else if (cpu_gnt && !cpu_we) begin
      owner_in = OWN_CPU;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!cpu_req || cpu_gnt) begin
      starve_cnt_next = '0;
    end else if (vid_gnt && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      mem_en         <= vid_gnt || cpu_gnt;
      mem_we         <= cpu_gnt && cpu_we;
      if (cpu_gnt) begin
        mem_addr <= cpu_addr;
        if (cpu_we) begin
          mem_wdata <= cpu_wdata;
        end
      end else if (vid_gnt) begin
        mem_addr <= vid_addr;
      end
    end
  end

  vram_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .owner_in  (owner_in),
    .owner_out (owner_ret)
  );

  assign vid_rvalid = (owner_ret == OWN_VID);
  assign cpu_rvalid = (owner_ret == OWN_CPU);
  assign vid_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt_reg, vid_grant_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_stall_cnt_reg <= '0;
      vid_grant_cnt_reg <= '0;
    end else if (stats_clr) begin
      cpu_stall_cnt_reg <= '0;
      vid_grant_cnt_reg <= '0;
    end else begin
      if (cpu_req && !cpu_gnt && (cpu_stall_cnt_reg != 16'hFFFF)) begin
        cpu_stall_cnt_reg <= cpu_stall_cnt_reg + 16'd1;
      end
      if (vid_gnt) begin
        vid_grant_cnt_reg <= vid_grant_cnt_reg + 16'd1;
      end
    end
  end

  assign cpu_stall_cnt = cpu_stall_cnt_reg;
  assign vid_grant_cnt = vid_grant_cnt_reg;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized self-checking bench for vram_arbiter against a slot-level model
// (grant rule, shadow memory, two-cycle read return). Stats checks need VRAM_ARB_STATS_EN.
module tb_vram_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]       cpu_stall_cnt, vid_grant_cnt;
  logic              stats_clr = 1'b0;
`endif

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
`ifdef VRAM_ARB_STATS_EN
    .cpu_stall_cnt(cpu_stall_cnt), .vid_grant_cnt(vid_grant_cnt), .stats_clr(stats_clr),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first BRAM primitive model.
  logic [DATA_W-1:0] bram [1<<ADDR_W];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
        mem_rdata      <= mem_wdata;
      end else begin
        mem_rdata <= bram[mem_addr];
      end
    end
  end

  // Reference model state: shadow memory and the last two granted slots.
  typedef struct {
    bit                en;
    bit                we;
    int                own;   // 0 none, 1 video, 2 cpu
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  logic [DATA_W-1:0] shadow [1<<ADDR_W];
  slot_t d1, d2, cur;
  int    wait_cnt;
  bit    last_vg, last_cg;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    d1 = '{default: 0};
    d2 = '{default: 0};
    wait_cnt = 0;
    last_vg = 0;
    last_cg = 0;
  endtask

  // One arbitration cycle: check grants, memory port and read return, then advance the model.
  task automatic step();
    bit eg_v, eg_c;
    @(negedge clk);
    eg_c = cpu_req && (!vid_req || wait_cnt == STARVE_MAX);
    eg_v = vid_req && !eg_c;
    chk("vid_gnt", 32'(vid_gnt), 32'(eg_v));
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("mem_en", 32'(mem_en), 32'(d1.en));
    if (d1.en) begin
      chk("mem_we", 32'(mem_we), 32'(d1.we));
      chk("mem_addr", 32'(mem_addr), 32'(d1.addr));
      if (d1.we) chk("mem_wdata", 32'(mem_wdata), 32'(d1.data));
    end
    chk("vid_rvalid", 32'(vid_rvalid), 32'(d2.own == 1));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(d2.own == 2));
    if (d2.own == 1) chk("vid_rdata", 32'(vid_rdata), 32'(d2.data));
    if (d2.own == 2) chk("cpu_rdata", 32'(cpu_rdata), 32'(d2.data));

    cur = '{default: 0};
    if (eg_v) begin
      cur.en = 1; cur.own = 1; cur.addr = vid_addr; cur.data = shadow[vid_addr];
    end else if (eg_c) begin
      cur.en = 1; cur.we = cpu_we; cur.addr = cpu_addr;
      if (cpu_we) begin
        cur.data = cpu_wdata;
        shadow[cpu_addr] = cpu_wdata;
      end else begin
        cur.own = 2; cur.data = shadow[cpu_addr];
      end
    end
    if (!cpu_req || eg_c) wait_cnt = 0;
    else if (eg_v && wait_cnt < STARVE_MAX) wait_cnt++;
    d2 = d1;
    d1 = cur;
    last_vg = eg_v;
    last_cg = eg_c;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    vid_req = 0; cpu_req = 0; cpu_we = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      bram[i]   = DATA_W'(i);
      shadow[i] = DATA_W'(i);
    end
    clear_model();
    #2;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rvalid", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;

    // Contention: expect V,V,V,V,C repeating.
    vid_req = 1; vid_addr = 14'h0040;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0050;
    for (int i = 0; i < 20; i++) begin
      step();
      $display("contention cycle %0d: vid_gnt=%0d cpu_gnt=%0d", i, last_vg, last_cg);
    end
    set_idle();
    step(); step();
`ifdef VRAM_ARB_STATS_EN
    chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'd16);
    chk("vid_grant_cnt", 32'(vid_grant_cnt), 32'd16);
    stats_clr = 1;
    step();
    stats_clr = 0;
    chk("stall_clr", 32'(cpu_stall_cnt), 32'd0);
    chk("vgrant_clr", 32'(vid_grant_cnt), 32'd0);
`endif

    // Video-only burst.
    for (int i = 0; i < 8; i++) begin
      vid_req = 1; vid_addr = ADDR_W'(14'h0100 + i);
      step();
      $display("burst addr=%0h vid_gnt=%0d", vid_addr, last_vg);
    end
    set_idle();
    step(); step();

    // CPU write then read of the same address.
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1234; cpu_wdata = 8'hA5;
    step();
    cpu_we = 0;
    step();
    set_idle();
    step();
    chk("raw_data", 32'(cpu_rdata), 32'hA5);
    step();
    $display("write/read 0x1234 done");

    // Interleaved ownership.
    vid_req = 1; vid_addr = 14'h0010; step();
    vid_req = 0; cpu_req = 1; cpu_addr = 14'h0020; step();
    cpu_req = 0; vid_req = 1; vid_addr = 14'h0030; step();
    set_idle();
    step(); step();
    $display("interleaved sequence done");

    // Reset one cycle after a CPU read grant.
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0077; step();
    set_idle();
    reset = 0;
    #1;
    chk("async_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("rst_mid_rvalid", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
    @(negedge clk);
    reset = 1;
    clear_model();
    @(posedge clk); #1;
    step(); step();
    cpu_req = 1; cpu_addr = 14'h0078; step();
    set_idle();
    step(); step();
    $display("reset mid-flight done");

    // Randomized traffic over a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      if (!vid_req || last_vg) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = ADDR_W'($urandom_range(0, 31));
      end else if ($urandom_range(0, 15) == 0) begin
        vid_req = 0;
      end
      if (!cpu_req || last_cg) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = ADDR_W'($urandom_range(0, 31));
        cpu_wdata = DATA_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        cpu_req = 0;
      end
      step();
      $display("rand %0d: vid_gnt=%0d cpu_gnt=%0d vid_rvalid=%0d cpu_rvalid=%0d",
               i, last_vg, last_cg, vid_rvalid, cpu_rvalid);
    end
    set_idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM (synchronous read, 1-cycle BRAM latency) between the scan-out fetch path and the CPU.
- Sits between the chip core and the VRAM primitive on the 40 MHz CPU/video clock.
- Video has fixed priority. A starvation limiter guarantees the CPU a slot after STARVE_MAX consecutive video grants.
- Read data returns to the owning requester through a 2-stage ownership tag pipeline.

Parameters:
ADDR_W, 14, VRAM address width
DATA_W, 8, VRAM data width
STARVE_MAX, 4, consecutive video grants allowed while the CPU is waiting (1..15)

Ports:
clk  in  1  single clock (40 MHz domain)
reset  in  1  asynchronous reset, active-low
vid_req  in  1  video fetch request; held with vid_addr until vid_gnt
vid_addr  in  ADDR_W  video read address
vid_gnt  out  1  video request accepted this cycle (combinational)
vid_rvalid  out  1  vid_rdata valid
vid_rdata  out  DATA_W  video read data
cpu_req  in  1  CPU request; held with cpu_we/addr/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid (reads only)
cpu_rdata  out  DATA_W  CPU read data
mem_en  out  1  VRAM enable (registered)
mem_we  out  1  VRAM write enable (registered)
mem_addr  out  ADDR_W  VRAM address (registered)
mem_wdata  out  DATA_W  VRAM write data (registered)
mem_rdata  in  DATA_W  VRAM read data, valid one cycle after mem_en

Behaviour:
- Reset (async assert, sync deassert by the upstream POR):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Tag pipeline = OWN_NONE; starve_cnt=0; all rvalid=0.
- Arbitration, combinational per cycle:
  - Neither request: no grant.
  - Only one request: that requester is granted.
  - Both requesting: CPU is granted if starve_cnt==STARVE_MAX, else video.
- At most one grant per cycle. vid_gnt and cpu_gnt are never both 1.
- starve_cnt:
  - Increments on a video grant while cpu_req=1, saturating at STARVE_MAX.
  - Clears on a CPU grant, or on any cycle with cpu_req=0.
- Grant in cycle N:
  - mem_* registered at the end of N, driven during N+1.
  - BRAM samples at the end of N+1; mem_rdata is valid during N+2.
- Ownership tags: tag0 <= owner(N); tag1 <= tag0, restricted to reads.
  - A CPU write enters as OWN_NONE and never produces rvalid.
- Read return in cycle N+2:
  - vid_rvalid=(tag1==OWN_VID) and cpu_rvalid=(tag1==OWN_CPU), with the matching rdata = mem_rdata passed through.
  - Fixed read latency: exactly 2 cycles after grant. A write commits at the end of N+1.
- Idle cycle: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last value.
- Back-to-back grants are allowed every cycle, with full throughput.
- Read-after-write to the same address in consecutive slots returns the new data (BRAM write-first mode is required of the primitive).
- Request withdrawn before grant: legal, no side effects. A request must not change address while held.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced; a write registered but not yet committed is discarded (mem_en forced 0).

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined:
  - Adds output cpu_stall_cnt [15:0]: counts cycles with cpu_req=1 and cpu_gnt=0, saturating at 16'hFFFF.
  - Adds output vid_grant_cnt [15:0]: wrapping count of video grants.
  - Adds input stats_clr: synchronous clear of both counters, taking priority over increment.
  - Both counters reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package vram_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_VID, OWN_CPU}.
  - Localparam RD_LATENCY=2.
- One sub-module, vram_tag_pipe: the 2-stage owner_t shift register with async active-low reset.
- Arbitration, starvation counter and mem_* registers stay in vram_arbiter.

Test Plan:
- Video-only burst: vid_req held 8 cycles, addrs 0x0100..0x0107, memory model data=addr[7:0]. Required: vid_gnt every cycle; vid_rvalid 2 cycles after each grant with data 0x00..0x07.
- Contention: both requesting continuously, STARVE_MAX=4. Required: grant pattern V,V,V,V,C repeating; starve_cnt never exceeds 4; cpu_gnt and vid_gnt never both 1.
- CPU write then read: write 0xA5 to 0x1234, next cycle read 0x1234. Required: cpu_rvalid exactly 2 cycles after the read grant with 0xA5; no rvalid for the write; no vid_rvalid.
- Interleaved ownership: V-read 0x0010, C-read 0x0020, V-read 0x0030 in consecutive cycles. Required: data returned in order to vid, cpu, vid, each with no cross-assertion of rvalid.
- Reset mid-flight: assert reset (low) one cycle after a CPU read grant. Required: mem_en=0 immediately (async); no cpu_rvalid after release; the first post-reset grant behaves normally.
- With VRAM_ARB_STATS_EN, contention for 20 cycles. Required: cpu_stall_cnt=16, vid_grant_cnt=16. Then stats_clr=1 for one cycle clears both to 0.
